// File: rtl/rv32im_decode_stage.sv
// rv32im_decode_stage: RV32IM instruction decode with a registered ID/EX boundary.
// Ports: CLK/RESET (sync, active-high); IN_VALID, INSTR, PC_IN from IF/ID;
//        STALL holds the output stage, FLUSH loads a bubble (NOP decode, OUT_VALID=0);
//        outputs OUT_VALID, PC_OUT, ALU_OPCODE, IMM, OP1_SEL, OP2_SEL, RS1/RS2/RD_ADDR,
//        FUNCT3, REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP, ILLEGAL.
// Optional: define RV32M_EN to decode funct7=0000001 OP instructions as M-extension ops;
//           without it they are reported ILLEGAL.
module rv32im_decode_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            IN_VALID,
    input  logic [31:0]     INSTR,
    input  logic [XLEN-1:0] PC_IN,
    input  logic            STALL,
    input  logic            FLUSH,
    output logic            OUT_VALID,
    output logic [XLEN-1:0] PC_OUT,
    output logic [4:0]      ALU_OPCODE,
    output logic [XLEN-1:0] IMM,
    output logic [1:0]      OP1_SEL,
    output logic            OP2_SEL,
    output logic [4:0]      RS1_ADDR,
    output logic [4:0]      RS2_ADDR,
    output logic [4:0]      RD_ADDR,
    output logic [2:0]      FUNCT3,
    output logic            REG_WRITE_EN,
    output logic            MEM_READ,
    output logic            MEM_WRITE,
    output logic            BRANCH,
    output logic            JUMP,
    output logic            ILLEGAL
);
    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SRL = 5'd3, SRA = 5'd4,
                           SLT = 5'd5, SLTU = 5'd6, AND = 5'd7, OR = 5'd8, XOR = 5'd9;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BR = 7'b1100011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      alu;
        logic [XLEN-1:0] imm;
        logic [1:0]      op1;
        logic            op2;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      f3;
        logic            we;
        logic            mr;
        logic            mw;
        logic            br;
        logic            jp;
        logic            ill;
    } dec_t;

    // alt selects SUB/SRA (inst[30]) where that bit is an opcode modifier.
    function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  base_alu = alt ? SUB : ADD;
            3'b001:  base_alu = SLL;
            3'b010:  base_alu = SLT;
            3'b011:  base_alu = SLTU;
            3'b100:  base_alu = XOR;
            3'b101:  base_alu = alt ? SRA : SRL;
            3'b110:  base_alu = OR;
            default: base_alu = AND;
        endcase
    endfunction

`ifdef RV32M_EN
    function automatic logic [4:0] mul_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  mul_alu = 5'd10;
            3'b001:  mul_alu = 5'd11;
            3'b010:  mul_alu = 5'd13;
            3'b011:  mul_alu = 5'd12;
            3'b100:  mul_alu = 5'd14;
            3'b101:  mul_alu = 5'd15;
            3'b110:  mul_alu = 5'd16;
            default: mul_alu = 5'd17;
        endcase
    endfunction
`endif

    function automatic dec_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc,
                                    input logic vld);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3       = ins[14:12];
        f7       = ins[31:25];
        d        = '0;
        d.valid  = vld;
        d.pc     = pc;
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.rd     = ins[11:7];
        d.f3     = f3;
        case (ins[6:0])
            LUI: begin
                d.imm = {ins[31:12], 12'b0};
                d.op1 = 2'b10;
                d.op2 = 1'b1;
                d.we  = 1'b1;
            end
            AUIPC: begin
                d.imm = {ins[31:12], 12'b0};
                d.op1 = 2'b01;
                d.op2 = 1'b1;
                d.we  = 1'b1;
            end
            JAL: begin
                d.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                d.op1 = 2'b01;
                d.op2 = 1'b1;
                d.jp  = 1'b1;
                d.we  = 1'b1;
            end
            JALR: begin
                d.imm = {{20{ins[31]}}, ins[31:20]};
                d.op2 = 1'b1;
                d.jp  = 1'b1;
                d.we  = 1'b1;
                d.ill = f3 != 3'b000;
            end
            BR: begin
                d.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                d.alu = !f3[2] ? SUB : f3[1] ? SLTU : SLT;
                d.br  = 1'b1;
                d.ill = f3[2:1] == 2'b01;
            end
            LOAD: begin
                d.imm = {{20{ins[31]}}, ins[31:20]};
                d.op2 = 1'b1;
                d.mr  = 1'b1;
                d.we  = 1'b1;
                d.ill = f3 == 3'b011 || f3[2:1] == 2'b11;
            end
            STORE: begin
                d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                d.op2 = 1'b1;
                d.mw  = 1'b1;
                d.ill = f3[2] || f3 == 3'b011;
            end
            OPIMM: begin
                d.op2 = 1'b1;
                d.we  = 1'b1;
                if (f3[1:0] == 2'b01) begin
                    // shifts: the upper immediate bits are funct7, shamt is zero-extended
                    d.imm = {27'b0, ins[24:20]};
                    d.alu = base_alu(f3, f7[5]);
                    d.ill = !(f7 == 7'b0000000 || (f3[2] && f7 == 7'b0100000));
                end else begin
                    d.imm = {{20{ins[31]}}, ins[31:20]};
                    d.alu = base_alu(f3, 1'b0);
                end
            end
            OP: begin
                d.we = 1'b1;
                case (f7)
                    7'b0000000: d.alu = base_alu(f3, 1'b0);
                    7'b0100000: begin
                        d.alu = base_alu(f3, 1'b1);
                        d.ill = !(f3 == 3'b000 || f3 == 3'b101);
                    end
`ifdef RV32M_EN
                    7'b0000001: d.alu = mul_alu(f3);
`else
                    7'b0000001: d.ill = 1'b1;
`endif
                    default: d.ill = 1'b1;
                endcase
            end
            default: d.ill = 1'b1;
        endcase
        if (d.ill) begin
            d.alu = ADD;
            d.op1 = 2'b00;
            d.op2 = 1'b0;
            {d.we, d.mr, d.mw, d.br, d.jp} = '0;
        end
        if (!vld) begin
            {d.we, d.mr, d.mw, d.br, d.jp, d.ill} = '0;
        end
        return d;
    endfunction

    dec_t dec_q, dec_d, nop_d;

    always_comb begin
        dec_d = decode(INSTR, PC_IN, IN_VALID);
        nop_d = decode(NOP_INSTR, '0, 1'b0);
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            dec_q <= '0;
        else if (FLUSH)
            dec_q <= nop_d;
        else if (!STALL)
            dec_q <= dec_d;
    end

    assign OUT_VALID    = dec_q.valid;
    assign PC_OUT       = dec_q.pc;
    assign ALU_OPCODE   = dec_q.alu;
    assign IMM          = dec_q.imm;
    assign OP1_SEL      = dec_q.op1;
    assign OP2_SEL      = dec_q.op2;
    assign RS1_ADDR     = dec_q.rs1;
    assign RS2_ADDR     = dec_q.rs2;
    assign RD_ADDR      = dec_q.rd;
    assign FUNCT3       = dec_q.f3;
    assign REG_WRITE_EN = dec_q.we;
    assign MEM_READ     = dec_q.mr;
    assign MEM_WRITE    = dec_q.mw;
    assign BRANCH       = dec_q.br;
    assign JUMP         = dec_q.jp;
    assign ILLEGAL      = dec_q.ill;
endmodule

// File: tb/tb_rv32im_decode_stage.sv
// tb_rv32im_decode_stage: randomized scoreboard bench for rv32im_decode_stage.
module tb_rv32im_decode_stage;
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  alu;
        logic [31:0] imm;
        logic [1:0]  op1;
        logic        op2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        we;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic        ill;
    } o_t;

    // ALU codes indexed by funct3 for base and M-extension register ops
    localparam logic [4:0] BASE [8] = '{5'd0, 5'd2, 5'd5, 5'd6, 5'd9, 5'd3, 5'd8, 5'd7};
    localparam logic [4:0] MEXT [8] = '{5'd10, 5'd11, 5'd13, 5'd12, 5'd14, 5'd15, 5'd16, 5'd17};
    localparam logic [6:0] OPCS [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    logic        CLK = 0, RESET = 0, IN_VALID = 0, STALL = 0, FLUSH = 0;
    logic [31:0] INSTR = 0, PC_IN = 0;
    logic        OUT_VALID, OP2_SEL, REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP, ILLEGAL;
    logic [31:0] PC_OUT, IMM;
    logic [4:0]  ALU_OPCODE, RS1_ADDR, RS2_ADDR, RD_ADDR;
    logic [1:0]  OP1_SEL;
    logic [2:0]  FUNCT3;

    int errors = 0, checks = 0, pushed = 0;
    o_t exp_q[$];
    o_t model;

    rv32im_decode_stage dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .INSTR(INSTR), .PC_IN(PC_IN),
        .STALL(STALL), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .PC_OUT(PC_OUT),
        .ALU_OPCODE(ALU_OPCODE), .IMM(IMM), .OP1_SEL(OP1_SEL), .OP2_SEL(OP2_SEL),
        .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .RD_ADDR(RD_ADDR), .FUNCT3(FUNCT3),
        .REG_WRITE_EN(REG_WRITE_EN), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .BRANCH(BRANCH), .JUMP(JUMP), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    function automatic o_t ref_dec(input logic [31:0] i, input logic [31:0] pc, input logic v);
        o_t         o;
        logic       ok;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] imm_i;
        o     = '0;
        ok    = 1;
        f3    = i[14:12];
        f7    = i[31:25];
        imm_i = {{20{i[31]}}, i[31:20]};
        o.v   = v;
        o.pc  = pc;
        o.rs1 = i[19:15];
        o.rs2 = i[24:20];
        o.rd  = i[11:7];
        o.f3  = f3;
        case (i[6:0])
            7'h37: begin o.imm = {i[31:12], 12'h000}; o.op1 = 2; o.op2 = 1; o.we = 1; end
            7'h17: begin o.imm = {i[31:12], 12'h000}; o.op1 = 1; o.op2 = 1; o.we = 1; end
            7'h6f: begin
                o.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                o.op1 = 1; o.op2 = 1; o.jp = 1; o.we = 1;
            end
            7'h67: begin o.imm = imm_i; o.op2 = 1; o.jp = 1; o.we = 1; ok = f3 == 0; end
            7'h63: begin
                o.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                o.br  = 1;
                o.alu = (f3 inside {0, 1}) ? 5'd1 : (f3 inside {4, 5}) ? 5'd5 : 5'd6;
                ok    = !(f3 inside {2, 3});
            end
            7'h03: begin o.imm = imm_i; o.op2 = 1; o.mr = 1; o.we = 1; ok = f3 inside {0, 1, 2, 4, 5}; end
            7'h23: begin
                o.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                o.op2 = 1; o.mw = 1; ok = f3 inside {0, 1, 2};
            end
            7'h13: begin
                o.op2 = 1; o.we = 1;
                if (f3 == 1 || f3 == 5) begin
                    o.imm = 32'(i[24:20]);
                    o.alu = (f3 == 5 && f7 == 7'h20) ? 5'd4 : BASE[f3];
                    ok    = f7 == 0 || (f3 == 5 && f7 == 7'h20);
                end else begin
                    o.imm = imm_i;
                    o.alu = BASE[f3];
                end
            end
            7'h33: begin
                o.we = 1;
                if (f7 == 0) o.alu = BASE[f3];
                else if (f7 == 7'h20) begin
                    o.alu = f3 == 0 ? 5'd1 : 5'd4;
                    ok    = f3 == 0 || f3 == 5;
                end else if (f7 == 7'h01) begin
`ifdef RV32M_EN
                    o.alu = MEXT[f3];
`else
                    ok = 0;
`endif
                end else ok = 0;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            o.ill = 1;
            o.alu = 0; o.op1 = 0; o.op2 = 0;
            o.we = 0; o.mr = 0; o.mw = 0; o.br = 0; o.jp = 0;
        end
        if (!v) begin
            o.we = 0; o.mr = 0; o.mw = 0; o.br = 0; o.jp = 0; o.ill = 0;
        end
        return o;
    endfunction

    // Apply one cycle of stimulus, advance the reference register, queue its expected value.
    task automatic step(input logic rst, input logic fl, input logic st, input logic v,
                        input logic [31:0] ins, input logic [31:0] pc);
        RESET = rst; FLUSH = fl; STALL = st; IN_VALID = v; INSTR = ins; PC_IN = pc;
        if (rst) model = '0;
        else if (fl) model = ref_dec(32'h00000013, 32'h0, 1'b0);
        else if (!st) model = ref_dec(ins, pc, v);
        @(posedge CLK);
        #1;
        exp_q.push_back(model);
        pushed++;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            o_t e, a;
            e = exp_q.pop_front();
            a = '{OUT_VALID, PC_OUT, ALU_OPCODE, IMM, OP1_SEL, OP2_SEL, RS1_ADDR, RS2_ADDR,
                  RD_ADDR, FUNCT3, REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP, ILLEGAL};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL decode#%0d actual=%h required=%h (alu %0d/%0d imm %h/%h we %b/%b ill %b/%b v %b/%b)",
                         checks, a, e, a.alu, e.alu, a.imm, e.imm, a.we, e.we, a.ill, e.ill, a.v, e.v);
            end
        end
    end

    initial begin
        logic [31:0] ins;
        int          k;
        model = '0;
        @(negedge CLK);
        step(1, 0, 0, 1, 32'h002081B3, 32'h100);
        step(1, 0, 0, 1, 32'h002081B3, 32'h100);
        step(0, 0, 0, 1, 32'h002081B3, 32'h104);
        step(0, 0, 0, 1, 32'hFFF00093, 32'h108);
        step(0, 0, 0, 1, 32'h40335293, 32'h10C);
        step(0, 0, 0, 1, 32'h02C5B533, 32'h110);
        step(0, 0, 0, 1, 32'h002081B3, 32'h114);
        step(0, 0, 1, 1, 32'hFFF00093, 32'h118);
        step(0, 0, 1, 1, 32'hFFF00093, 32'h118);
        step(0, 0, 0, 1, 32'hFFF00093, 32'h118);
        step(0, 1, 1, 1, 32'h002081B3, 32'h11C);
        step(0, 0, 0, 1, 32'hFFFFFFFF, 32'h120);
        step(0, 0, 0, 0, 32'h002081B3, 32'h124);
        step(0, 0, 0, 1, 32'h0000006F, 32'h128);
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            k   = $urandom_range(0, 9);
            if (k < 9) ins[6:0] = OPCS[k];
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0: ins[31:25] = 7'h00;
                    1: ins[31:25] = 7'h20;
                    2: ins[31:25] = 7'h01;
                    default: ;
                endcase
            end
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 85, ins, $urandom);
        end
        RESET = 0; FLUSH = 0; STALL = 1;
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge CLK);
        @(posedge CLK);
        if (exp_q.size() != 0 || checks != pushed) begin
            errors++;
            $display("FAIL drain: checked %0d of %0d queued responses", checks, pushed);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
